// File: rtl/fp_mul_issue_ctrl_pkg.sv
// Shared types and default parameters for the floating-point multiplier
// issue controller and its operand FIFO.
package fp_mul_pkg;

  localparam int FP_W = 32;

  localparam int DEF_FIFO_DEPTH  = 4;
  localparam int DEF_HOLD_CYCLES = 2;
  localparam int DEF_MUL_LATENCY = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_HOLD,
    ST_WAIT,
    ST_DONE
  } fp_issue_state_t;

  // One buffered operand pair; a occupies the upper half of the 64-bit entry.
  typedef struct packed {
    logic [FP_W-1:0] a;
    logic [FP_W-1:0] b;
  } fp_pair_t;

  // Width of a down-counter that must hold values 0..max_val.
  function automatic int down_cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/fp_mul_issue_ctrl_if.sv
// Handshake bundle of the issue controller: operand input stream, multiplier
// start/operand/result side and result output stream.
interface fp_mul_issue_ctrl_if;
  import fp_mul_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [FP_W-1:0] in_a;
  logic [FP_W-1:0] in_b;

  logic            mul_start;
  logic [FP_W-1:0] mul_a;
  logic [FP_W-1:0] mul_b;
  logic [FP_W-1:0] mul_result;
  logic            mul_overflow;

  logic            out_valid;
  logic            out_ready;
  logic [FP_W-1:0] out_result;
  logic            out_overflow;

  // Controller side.
  modport slave (
    input  in_valid, in_a, in_b, mul_result, mul_overflow, out_ready,
    output in_ready, mul_start, mul_a, mul_b, out_valid, out_result, out_overflow
  );

  // Environment side: producer, multiplier and consumer.
  modport master (
    output in_valid, in_a, in_b, mul_result, mul_overflow, out_ready,
    input  in_ready, mul_start, mul_a, mul_b, out_valid, out_result, out_overflow
  );

endinterface

// File: rtl/fp_mul_issue_ctrl_fifo.sv
// Synchronous operand FIFO holding {a,b} pairs. The head entry is visible on
// rd_data without a read latency so the controller can load it on the pop edge.
module fp_operand_fifo
  import fp_mul_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  fp_pair_t               wr_data,
  output fp_pair_t               rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  fp_pair_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  // A push while full is dropped even if a pop frees a slot the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are only observed while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/fp_mul_issue_ctrl.sv
// Issue controller around a fixed-latency floating-point multiplier: pulls
// operand pairs from a FIFO, drives the start/operand hold pattern, captures
// the product after MUL_LATENCY cycles and offers it on a valid/ready stream.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no operation outstanding, FIFO empty
//   ISSUE | mul_start pulse, operands driven (first hold cycle)
//   HOLD  | operands still driven, no start (HOLD_CYCLES-1 cycles)
//   WAIT  | operands zeroed, counting down to the capture edge
//   DONE  | product held on out_result until the consumer accepts it
module fp_mul_issue_ctrl
  import fp_mul_pkg::*;
#(
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int MUL_LATENCY = DEF_MUL_LATENCY
) (
  input  logic                clk,
  input  logic                reset,
  fp_mul_issue_ctrl_if.slave  bus,
  output logic                busy,
  output logic [7:0]          ovf_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = down_cnt_width(MUL_LATENCY);

  // The counter is loaded with MUL_LATENCY on the ISSUE entry edge and hits
  // zero in the last cycle before capture, so ISSUE..WAIT spans
  // MUL_LATENCY+1 cycles.
  localparam logic [CW-1:0] CNT_LOAD = CW'(MUL_LATENCY);
  // Counter value seen in the final HOLD cycle.
  localparam logic [CW-1:0] HOLD_END = CW'(MUL_LATENCY - HOLD_CYCLES + 1);

  fp_issue_state_t state;
  logic [CW-1:0]   cnt;

  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [AW:0]     fifo_count;
  fp_pair_t        fifo_wr;
  fp_pair_t        fifo_head;

  logic            mul_start_q;
  logic [FP_W-1:0] mul_a_q;
  logic [FP_W-1:0] mul_b_q;
  logic            out_valid_q;
  logic [FP_W-1:0] out_result_q;
  logic            out_overflow_q;

  assign fifo_wr   = '{a: bus.in_a, b: bus.in_b};
  assign fifo_push = bus.in_valid && !fifo_full;
  // Popping is exactly the condition for entering ISSUE.
  assign fifo_pop  = !fifo_empty &&
                     ((state == ST_IDLE) || ((state == ST_DONE) && bus.out_ready));

  fp_operand_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wr_data (fifo_wr),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign bus.in_ready     = !fifo_full;
  assign bus.mul_start    = mul_start_q;
  assign bus.mul_a        = mul_a_q;
  assign bus.mul_b        = mul_b_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_result   = out_result_q;
  assign bus.out_overflow = out_overflow_q;
  assign busy             = (state != ST_IDLE) || (fifo_count != '0);

  // Sequencer: state, hold/latency counter, multiplier drive, capture and
  // overflow statistics, all registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      mul_start_q    <= 1'b0;
      mul_a_q        <= '0;
      mul_b_q        <= '0;
      out_valid_q    <= 1'b0;
      out_result_q   <= '0;
      out_overflow_q <= 1'b0;
      ovf_count      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state <= ST_IDLE;
        end

        ST_ISSUE: begin
          mul_start_q <= 1'b0;
          cnt         <= cnt - 1'b1;
          if (HOLD_CYCLES > 1) begin
            state <= ST_HOLD;
          end else begin
            state   <= ST_WAIT;
            mul_a_q <= '0;
            mul_b_q <= '0;
          end
        end

        ST_HOLD: begin
          cnt <= cnt - 1'b1;
          if (cnt == HOLD_END) begin
            state   <= ST_WAIT;
            mul_a_q <= '0;
            mul_b_q <= '0;
          end
        end

        ST_WAIT: begin
          if (cnt == '0) begin
            state          <= ST_DONE;
            out_valid_q    <= 1'b1;
            out_result_q   <= bus.mul_result;
            out_overflow_q <= bus.mul_overflow;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        ST_DONE: begin
          if (bus.out_ready) begin
            state       <= ST_IDLE;
            out_valid_q <= 1'b0;
            if (out_overflow_q && (ovf_count != 8'hFF)) begin
              ovf_count <= ovf_count + 8'd1;
            end
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase

      // Starting a new operation overrides the IDLE/DONE next-state choice.
      if (fifo_pop) begin
        state       <= ST_ISSUE;
        cnt         <= CNT_LOAD;
        mul_start_q <= 1'b1;
        mul_a_q     <= fifo_head.a;
        mul_b_q     <= fifo_head.b;
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_issue_ctrl.sv
// Scoreboard bench for fp_mul_issue_ctrl with a behavioural multiplier that
// only presents a valid product in the capture cycle.
module tb_fp_mul_issue_ctrl;
  import fp_mul_pkg::*;

  localparam int HOLD    = DEF_HOLD_CYCLES;
  localparam int MUL_LAT = DEF_MUL_LATENCY;
  // Negedges from the one before the push edge to the first out_valid cycle:
  // push edge, bubble, ISSUE..WAIT (MUL_LAT+1 cycles).
  localparam int LAT_NEG = MUL_LAT + 3;
  localparam int TMO     = 3000;

  typedef struct {
    logic [31:0] r;
    logic        o;
    int          push_cyc;
    bit          lat_chk;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       busy;
  logic [7:0] ovf_count;

  fp_mul_issue_ctrl_if bus ();

  fp_mul_issue_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .busy      (busy),
    .ovf_count (ovf_count)
  );

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          ref_ovf = 0;
  int          stub_k = -1;
  logic [31:0] last_res = '0;
  bit          prev_ov = 0;
  bit          rnd_done = 0;
  exp_t        exp_q[$];
  logic [63:0] opq[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic fail_evt(input string name);
    checks++;
    failures++;
    $display("FAIL %s: actual=no_event required=event", name);
  endtask

  // Truncating IEEE single multiply for normal operands; zero/denormal
  // inputs flush to zero, Inf/NaN inputs give NaN. Returns {overflow, product}.
  function automatic logic [32:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    int          ea;
    int          eb;
    int          e;
    logic [47:0] p;
    logic [22:0] m;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (ea == 255 || eb == 255) return {1'b0, s, 8'hFF, 23'h400000};
    if (ea == 0 || eb == 0) return {1'b0, s, 31'h0};
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = ea + eb - 127;
    if (p[47]) begin
      m = p[46:24];
      e++;
    end else begin
      m = p[45:23];
    end
    if (e >= 255) return {1'b1, s, 8'hFF, 23'h0};
    if (e <= 0) return {1'b0, s, 31'h0};
    return {1'b0, s, 8'(e), m};
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 5))
      0: v = 32'h7FC00000;
      1: v = {v[31], 8'h00, v[22:0]};
      2: v = {v[31], 8'hFE, v[22:0]};
      3: v = {v[31], 8'hFF, 23'h0};
      default: v = v;
    endcase
    return v;
  endfunction

  // Scoreboard: record accepted pushes, compare accepted results.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      exp_q.delete();
      opq.delete();
      ref_ovf = 0;
      prev_ov = 0;
    end else begin
      if (bus.out_valid) begin
        chk("no_start_in_done", 32'(bus.mul_start), 32'd0);
        if (!prev_ov && exp_q.size() > 0 && exp_q[0].lat_chk)
          chk("latency", cyc - exp_q[0].push_cyc, LAT_NEG);
        if (bus.out_ready) begin
          if (exp_q.size() == 0) begin
            fail_evt("unexpected_output");
          end else begin
            e = exp_q.pop_front();
            chk("out_result", bus.out_result, e.r);
            chk("out_overflow", 32'(bus.out_overflow), 32'(e.o));
            chk("ovf_count", 32'(ovf_count), ref_ovf);
            if (e.o && ref_ovf < 255) ref_ovf++;
            last_res = bus.out_result;
          end
        end
      end
      prev_ov = bus.out_valid;
      if (bus.in_valid && bus.in_ready) begin
        logic [32:0] f;
        f = fmul(bus.in_a, bus.in_b);
        e.r = f[31:0];
        e.o = f[32];
        e.push_cyc = cyc;
        e.lat_chk = (exp_q.size() == 0);
        exp_q.push_back(e);
        opq.push_back({bus.in_a, bus.in_b});
      end
    end
  end

  // Multiplier model: checks the start/hold pattern and presents the product
  // only during cycle ISSUE+MUL_LAT; random junk otherwise.
  always @(negedge clk) begin
    logic [63:0] op;
    logic [63:0] cur;
    logic [31:0] lat_a;
    logic [31:0] lat_b;
    logic [32:0] f;
    if (reset) begin
      stub_k = -1;
    end else begin
      if (bus.mul_start) begin
        chk("single_outstanding", stub_k, -1);
        if (opq.size() == 0) begin
          fail_evt("issue_without_push");
          op = '0;
        end else begin
          op = opq.pop_front();
          chk("issue_a", bus.mul_a, op[63:32]);
          chk("issue_b", bus.mul_b, op[31:0]);
        end
        cur = op;
        lat_a = bus.mul_a;
        lat_b = bus.mul_b;
        stub_k = 0;
      end else if (stub_k >= 0) begin
        stub_k++;
        if (stub_k < HOLD) begin
          chk("hold_a", bus.mul_a, cur[63:32]);
          chk("hold_b", bus.mul_b, cur[31:0]);
        end else begin
          chk("wait_zero_a", bus.mul_a, 32'd0);
          chk("wait_zero_b", bus.mul_b, 32'd0);
        end
      end else begin
        chk("idle_zero_a", bus.mul_a, 32'd0);
        chk("idle_zero_b", bus.mul_b, 32'd0);
      end
      if (stub_k == MUL_LAT) begin
        f = fmul(lat_a, lat_b);
        bus.mul_result = f[31:0];
        bus.mul_overflow = f[32];
        stub_k = -1;
      end else begin
        bus.mul_result = $urandom;
        bus.mul_overflow = 1'($urandom_range(0, 1));
      end
    end
  end

  task automatic push(input logic [31:0] a, input logic [31:0] b);
    int t;
    t = 0;
    bus.in_a = a;
    bus.in_b = b;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && t < TMO) begin
      t++;
      @(negedge clk);
    end
    if (t >= TMO) fail_evt("push_timeout");
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < TMO) begin
      @(negedge clk);
      t++;
    end
    if (t >= TMO) fail_evt("drain_timeout");
    repeat (3) @(posedge clk);
    #1;
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic check_reset_values();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_mul_start", 32'(bus.mul_start), 32'd0);
    chk("rst_mul_a", bus.mul_a, 32'd0);
    chk("rst_mul_b", bus.mul_b, 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_result", bus.out_result, 32'd0);
    chk("rst_out_overflow", 32'(bus.out_overflow), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovf_count", 32'(ovf_count), 32'd0);
  endtask

  initial begin
    int t;
    reset = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.out_ready = 1'b0;
    bus.mul_result = '0;
    bus.mul_overflow = 1'b0;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values();
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;

    // Directed products with an always-ready consumer.
    bus.out_ready = 1'b1;
    push(32'h3FC00000, 32'h40000000);
    drain();
    chk("dir_1p5x2", last_res, 32'h40400000);
    push(32'hC0400000, 32'hC0400000);
    drain();
    chk("dir_m3xm3", last_res, 32'h41100000);
    push(32'h7F000000, 32'h7F000000);
    drain();
    chk("dir_ovf_count", 32'(ovf_count), 32'd1);

    // Stalled consumer: four buffered plus one in flight fills the FIFO.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push(rnd_op(), rnd_op());
      if (i == 3) chk("in_ready_after_4", 32'(bus.in_ready), 32'd1);
    end
    chk("in_ready_full", 32'(bus.in_ready), 32'd0);
    repeat (10) @(posedge clk);
    #1;
    chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
    chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
    chk("stall_busy", 32'(busy), 32'd1);
    bus.out_ready = 1'b1;
    drain();

    // Random operands with random producer gaps and consumer back-pressure.
    rnd_done = 0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
          end
          push(rnd_op(), rnd_op());
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          bus.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.out_ready = 1'b1;
    drain();

    // Overflow counter saturation.
    for (int i = 0; i < 256; i++) push({1'($urandom_range(0, 1)), 31'h7F000000}, 32'h7F000000);
    drain();
    chk("ovf_saturated", 32'(ovf_count), 32'd255);

    // Reset one cycle into WAIT: everything clears, the product is dropped.
    push(32'h40000000, 32'h40400000);
    t = 0;
    @(negedge clk);
    #1;
    while (stub_k != HOLD && t < TMO) begin
      t++;
      @(negedge clk);
      #1;
    end
    if (t >= TMO) fail_evt("wait_state_timeout");
    #1 reset = 1'b1;
    #1;
    check_reset_values();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("post_rst_mul_start", 32'(bus.mul_start), 32'd0);
    end
    chk("leftover_expected", exp_q.size(), 32'd0);
    chk("leftover_operands", opq.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog: actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
